chan_err_inj: RTL and testbench
===============================

# chan_err_inj

Registered channel model between the rate-1/2 convolutional encoder and the Viterbi decoder. Each valid 2-bit code symbol passes through one register stage. On a pseudo-random trigger, the block corrupts a burst of consecutive symbols with an XOR mask. It also keeps symbol and bad-bit statistics so benches can correlate decoder errors with the injected channel bit error rate.

## Interface
Parameters:
- N, 5: trigger width. An event fires when lfsr[N-1:0] >= 2^N-2, giving probability 2/2^N. Legal range 1..28.
- BURST_LEN, 2: consecutive valid symbols corrupted per event. Legal range 1..15.
- SEED, 32'hACE1_2B8D: LFSR reset value. Must be nonzero.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable_i  in  1  d_in holds a valid symbol this cycle
- d_in  in  2  encoder code symbol
- inj_en  in  1  runtime injection gate
- clr_stats  in  1  synchronous clear of statistics
- valid_o  out  1  d_out valid
- d_out  out  2  channel output symbol
- err_o  out  1  d_out carries a nonzero error mask
- sym_ct_o  out  CNT_W  valid symbols passed, saturating
- bad_bit_ct_o  out  CNT_W  bits flipped, saturating

## Operation
- 32-bit Galois LFSR, taps 32'h8020_0003. Advances only in cycles where enable_i=1.
- Trigger is evaluated on the pre-advance LFSR value.
- Event mask = lfsr[29:28]. A mask of 2'b00 is coerced to 2'b11, so every event flips at least one bit.
- FSM, states IDLE and BURST:
  - IDLE, enable_i & inj_en & trigger: corrupt the current symbol with the mask and latch the mask. If BURST_LEN>1, load remaining=BURST_LEN-1 and go to BURST; otherwise stay in IDLE.
  - IDLE, any other condition: pass the symbol clean.
  - BURST, enable_i & inj_en: corrupt with the latched mask and decrement remaining. Return to IDLE when remaining reaches 0. New triggers are ignored in BURST.
  - BURST, enable_i=0: hold state, remaining and mask. Burst length counts symbols, not cycles.
  - BURST, inj_en=0: abort to IDLE. The current symbol passes clean.
- Statistics:
  - sym_ct_o increments on each enable_i.
  - bad_bit_ct_o adds popcount of the applied mask (0, 1 or 2).
  - Both counters saturate at 2^CNT_W-1. The add is done CNT_W+1 wide, then clamped.
  - clr_stats zeroes both counters and wins over a same-cycle increment.
- Reset: LFSR=SEED, FSM=IDLE, remaining=0, mask=0, valid_o=0, d_out=0, err_o=0, both counters 0.

## Timing
- Latency is 1 cycle. valid_o, d_out and err_o in cycle t+1 reflect enable_i and d_in in cycle t.
- When valid_o=0, d_out and err_o are 0.
- No backpressure. The block accepts a symbol every cycle.
- Counters update in the same edge as valid_o, so they reflect the symbol currently on d_out.
- rst mid-burst: the burst is discarded. The first valid symbol after reset is evaluated from IDLE with LFSR=SEED.
- inj_en and clr_stats are sampled every cycle, regardless of enable_i.

## Configuration
- CHAN_ERR_STATS_EN defined: counters are implemented as described.
- CHAN_ERR_STATS_EN undefined:
  - Counter logic is removed.
  - sym_ct_o and bad_bit_ct_o are tied to 0.
  - clr_stats is ignored.
  - Data path, FSM and err_o are unchanged.

## Structure
- Package chan_err_pkg holds:
  - the state enum (ST_IDLE, ST_BURST)
  - LFSR_TAPS = 32'h8020_0003
  - DEFAULT_SEED
  - a 2-bit popcount function
- Sub-module chan_lfsr:
  - 32-bit Galois LFSR
  - inputs: clk, rst, advance, seed
  - output: state
- FSM, masking and counters live in chan_err_inj.

## Test plan
- inj_en=0, d_in=2'b10 held, enable_i=1 for 8 cycles:
  - valid_o high from cycle 2, d_out=2'b10 throughout, err_o=0
  - sym_ct_o=8, bad_bit_ct_o=0
- N=1, BURST_LEN=2, inj_en=1, d_in=2'b00, 10 consecutive symbols:
  - every d_out is nonzero and err_o=1
  - outputs pair up with identical masks: (1,2), (3,4), ...
  - bad_bit_ct_o equals the sum of popcount(d_out)
- N=1, BURST_LEN=3, enable_i toggling 1,0,1,0,1: the three valid outputs share one mask, and the idle cycles show valid_o=0 with d_out=0.
- N=1, BURST_LEN=4, inj_en dropped after the second burst symbol: the third symbol passes clean. When inj_en returns, a new event starts with a fresh mask.
- CNT_W=4, N=1, 20 valid symbols:
  - sym_ct_o=15, bad_bit_ct_o=15 (saturated)
  - clr_stats pulsed with enable_i=1 gives both counters 0 on the next cycle
- rst asserted mid-burst, then the same stimulus replayed: the output sequence is identical to the sequence from the first reset.

Source files
------------

// File: rtl/chan_err_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chan_err_pkg
//  Description : Shared types, constants and helpers for the channel error
//                injector (state encoding, LFSR taps, default seed, popcount).
//  Revision    : 1.0  initial release
// ============================================================================
package chan_err_pkg;

    // Injection FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Galois feedback taps applied when the bit shifted out is 1
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2B8D;

    // Number of set bits in a 2-bit error mask
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : chan_lfsr
//  Description : 32-bit right-shifting Galois LFSR. Advances one step in each
//                cycle where advance=1, reloads seed on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module chan_lfsr
    import chan_err_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    logic [31:0] state_d;
    logic [31:0] state_q;

    // Next state: shift right, fold taps back in when a 1 leaves bit 0
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/chan_err_inj.sv
`default_nettype none
// ============================================================================
//  Module      : chan_err_inj
//  Description : Registered channel model between convolutional encoder and
//                Viterbi decoder. Corrupts bursts of BURST_LEN valid symbols
//                with an XOR mask on a pseudo-random trigger and keeps
//                saturating symbol / flipped-bit statistics.
//                Define CHAN_ERR_STATS_EN to build the statistics counters;
//                without it the counter outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module chan_err_inj
    import chan_err_pkg::*;
#(
    parameter int          N         = 5,
    parameter int          BURST_LEN = 2,
    parameter logic [31:0] SEED      = DEFAULT_SEED,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [1:0]       d_in,
    input  logic             inj_en,
    input  logic             clr_stats,
    output logic             valid_o,
    output logic [1:0]       d_out,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] bad_bit_ct_o
);

    // Trigger fires when the low N LFSR bits reach 2^N-2 or above
    localparam logic [31:0] TRIG_MASK  = (32'd1 << N) - 32'd1;
    localparam logic [31:0] TRIG_THR   = (32'd1 << N) - 32'd2;
    localparam logic [3:0]  BURST_REM  = 4'(BURST_LEN - 1);
    localparam bit          MULTI_SYM  = (BURST_LEN > 1);

    logic [31:0] lfsr_state;
    logic        trigger;
    logic [1:0]  event_mask;
    logic [1:0]  applied_mask;

    state_e      state_d,  state_q;
    logic [3:0]  rem_d,    rem_q;
    logic [1:0]  mask_d,   mask_q;
    logic        valid_d,  valid_q;
    logic [1:0]  dout_d,   dout_q;
    logic        err_d,    err_q;

    // The LFSR only moves on valid symbols so that the error pattern is
    // tied to the symbol stream rather than to idle gaps.
    chan_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (enable_i),
        .seed    (SEED),
        .state   (lfsr_state)
    );

    // Trigger and mask are taken from the pre-advance LFSR value; an all-zero
    // mask is promoted to 2'b11 so every event flips at least one bit.
    always_comb begin
        trigger    = ((lfsr_state & TRIG_MASK) >= TRIG_THR);
        event_mask = (lfsr_state[29:28] == 2'b00) ? 2'b11 : lfsr_state[29:28];
    end

    // Injection FSM: next state, remaining count, latched mask, applied mask
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        mask_d       = mask_q;
        applied_mask = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && inj_en && trigger) begin
                    applied_mask = event_mask;
                    mask_d       = event_mask;
                    if (MULTI_SYM) begin
                        rem_d   = BURST_REM;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!inj_en) begin
                    // Abort: current symbol (if any) passes clean
                    state_d = ST_IDLE;
                    rem_d   = 4'd0;
                end else if (enable_i) begin
                    applied_mask = mask_q;
                    rem_d        = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = 4'd0;
            end
        endcase
    end

    // Output stage: outputs are zero whenever no valid symbol is present
    always_comb begin
        valid_d = enable_i;
        dout_d  = enable_i ? (d_in ^ applied_mask) : 2'b00;
        err_d   = enable_i && (applied_mask != 2'b00);
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= 4'd0;
            mask_q  <= 2'b00;
            valid_q <= 1'b0;
            dout_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign d_out   = dout_q;
    assign err_o   = err_q;

`ifdef CHAN_ERR_STATS_EN
    logic [CNT_W-1:0] sym_ct_d, sym_ct_q;
    logic [CNT_W-1:0] bad_ct_d, bad_ct_q;
    logic [CNT_W:0]   sym_sum;
    logic [CNT_W:0]   bad_sum;

    // Saturating counters: add one bit wide, clamp on carry-out; clear wins
    always_comb begin
        sym_sum  = {1'b0, sym_ct_q} + (CNT_W+1)'(enable_i);
        bad_sum  = {1'b0, bad_ct_q} + (CNT_W+1)'(popcount2(applied_mask));
        sym_ct_d = sym_sum[CNT_W] ? {CNT_W{1'b1}} : sym_sum[CNT_W-1:0];
        bad_ct_d = bad_sum[CNT_W] ? {CNT_W{1'b1}} : bad_sum[CNT_W-1:0];
        if (clr_stats) begin
            sym_ct_d = '0;
            bad_ct_d = '0;
        end
    end

    // Statistics registers, updated on the same edge as the output symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_ct_q <= '0;
            bad_ct_q <= '0;
        end else begin
            sym_ct_q <= sym_ct_d;
            bad_ct_q <= bad_ct_d;
        end
    end

    assign sym_ct_o     = sym_ct_q;
    assign bad_bit_ct_o = bad_ct_q;
`else
    logic unused_clr_stats;

    assign unused_clr_stats = clr_stats;
    assign sym_ct_o         = '0;
    assign bad_bit_ct_o     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chan_err_inj.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chan_err_inj
//  Description : Directed self-checking bench for chan_err_inj. Several DUT
//                configurations share one stimulus bus; each phase checks the
//                instance it targets. Expected masks come from a small
//                reference LFSR; counter expectations follow
//                CHAN_ERR_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chan_err_inj;

`ifdef CHAN_ERR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [31:0] SEED_V = 32'hACE1_2B8D;

    logic       clk = 1'b0;
    logic       rst, en, inj, clr;
    logic [1:0] din;

    int checks   = 0;
    int failures = 0;

    logic        v_def, e_def, v_b2, e_b2, v_b3, e_b3, v_b4, e_b4, v_sat, e_sat;
    logic [1:0]  d_def, d_b2, d_b3, d_b4, d_sat;
    logic [15:0] s_def, b_def, s_b2, b_b2, s_b3, b_b3, s_b4, b_b4;
    logic [3:0]  s_sat, b_sat;

    always #5 clk = ~clk;

    chan_err_inj #(.N(5), .BURST_LEN(2), .CNT_W(16)) u_def (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din), .inj_en(inj), .clr_stats(clr),
        .valid_o(v_def), .d_out(d_def), .err_o(e_def), .sym_ct_o(s_def), .bad_bit_ct_o(b_def));
    chan_err_inj #(.N(1), .BURST_LEN(2), .CNT_W(16)) u_b2 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din), .inj_en(inj), .clr_stats(clr),
        .valid_o(v_b2), .d_out(d_b2), .err_o(e_b2), .sym_ct_o(s_b2), .bad_bit_ct_o(b_b2));
    chan_err_inj #(.N(1), .BURST_LEN(3), .CNT_W(16)) u_b3 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din), .inj_en(inj), .clr_stats(clr),
        .valid_o(v_b3), .d_out(d_b3), .err_o(e_b3), .sym_ct_o(s_b3), .bad_bit_ct_o(b_b3));
    chan_err_inj #(.N(1), .BURST_LEN(4), .CNT_W(16)) u_b4 (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din), .inj_en(inj), .clr_stats(clr),
        .valid_o(v_b4), .d_out(d_b4), .err_o(e_b4), .sym_ct_o(s_b4), .bad_bit_ct_o(b_b4));
    chan_err_inj #(.N(1), .BURST_LEN(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .enable_i(en), .d_in(din), .inj_en(inj), .clr_stats(clr),
        .valid_o(v_sat), .d_out(d_sat), .err_o(e_sat), .sym_ct_o(s_sat), .bad_bit_ct_o(b_sat));

    // Reference Galois LFSR step
    function automatic logic [31:0] m_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Event mask taken from LFSR bits 29:28, zero promoted to 2'b11
    function automatic logic [1:0] m_mask(input logic [31:0] s);
        logic [1:0] m;
        m = s[29:28];
        return (m == 2'b00) ? 2'b11 : m;
    endfunction

    function automatic int pc2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle; outputs are sampled 1ns after the edge
    task automatic step(input logic e, input logic [1:0] d, input logic i, input logic c);
        en = e; din = d; inj = i; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; din = 2'b00; inj = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] m;
        logic [1:0]  mk, mb, exp_d;
        logic [1:0]  tbl [6];
        int          sum;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_tuple", 32'({v_def, e_def, d_def}), 32'h0);
        check("rst_sym", 32'(s_def), 32'h0);
        check("rst_bad", 32'(b_def), 32'h0);

        // ---------------- clean pass, injection gated off ----------------
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'b10, 1'b0, 1'b0);
            check($sformatf("clean_%0d", k), 32'({v_def, e_def, d_def}), 32'b1_0_10);
        end
        check("clean_sym", 32'(s_def), STATS ? 32'd8 : 32'd0);
        check("clean_bad", 32'(b_def), 32'd0);
        step(1'b0, 2'b10, 1'b0, 1'b0);
        check("clean_idle", 32'({v_def, e_def, d_def}), 32'h0);

        // ---------------- N=1, BURST_LEN=2: masks pair up ----------------
        do_reset();
        m = SEED_V; mk = 2'b00; sum = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) mk = m_mask(m);
            m = m_next(m);
            step(1'b1, 2'b00, 1'b1, 1'b0);
            sum += pc2(mk);
            check($sformatf("b2_%0d", k), 32'({v_b2, e_b2, d_b2}), 32'({1'b1, 1'b1, mk}));
        end
        check("b2_sym", 32'(s_b2), STATS ? 32'd10 : 32'd0);
        check("b2_bad", 32'(b_b2), STATS ? 32'(sum) : 32'd0);

        // ---------------- N=1, BURST_LEN=3, enable toggling ----------------
        do_reset();
        mk = m_mask(SEED_V);
        for (int k = 0; k < 5; k++) begin
            step((k % 2) == 0, 2'b01, 1'b1, 1'b0);
            if (k % 2 == 0)
                check($sformatf("b3_%0d", k), 32'({v_b3, e_b3, d_b3}), 32'({1'b1, 1'b1, 2'b01 ^ mk}));
            else
                check($sformatf("b3_%0d", k), 32'({v_b3, e_b3, d_b3}), 32'h0);
        end

        // ---------------- N=1, BURST_LEN=4, abort then fresh event ----------------
        do_reset();
        m  = SEED_V;
        mk = m_mask(m);
        step(1'b1, 2'b11, 1'b1, 1'b0); m = m_next(m);
        check("b4_s0", 32'({v_b4, e_b4, d_b4}), 32'({1'b1, 1'b1, 2'b11 ^ mk}));
        step(1'b1, 2'b11, 1'b1, 1'b0); m = m_next(m);
        check("b4_s1", 32'({v_b4, e_b4, d_b4}), 32'({1'b1, 1'b1, 2'b11 ^ mk}));
        step(1'b1, 2'b11, 1'b0, 1'b0); m = m_next(m);
        check("b4_abort", 32'({v_b4, e_b4, d_b4}), 32'b1_0_11);
        mb = m_mask(m);
        step(1'b1, 2'b11, 1'b1, 1'b0); m = m_next(m);
        check("b4_new0", 32'({v_b4, e_b4, d_b4}), 32'({1'b1, 1'b1, 2'b11 ^ mb}));
        step(1'b1, 2'b11, 1'b1, 1'b0);
        check("b4_new1", 32'({v_b4, e_b4, d_b4}), 32'({1'b1, 1'b1, 2'b11 ^ mb}));

        // ---------------- CNT_W=4 saturation and clear ----------------
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 2'b00, 1'b1, 1'b0);
        check("sat_sym", 32'(s_sat), STATS ? 32'd15 : 32'd0);
        check("sat_bad", 32'(b_sat), STATS ? 32'd15 : 32'd0);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        check("clr_sym", 32'(s_sat), 32'd0);
        check("clr_bad", 32'(b_sat), 32'd0);
        step(1'b1, 2'b00, 1'b1, 1'b0);
        check("post_clr_sym", 32'(s_sat), STATS ? 32'd1 : 32'd0);

        // ---------------- reset mid-burst, replay ----------------
        tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b10;
        tbl[3] = 2'b11; tbl[4] = 2'b01; tbl[5] = 2'b10;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            m = SEED_V; mk = 2'b00;
            for (int k = 0; k < 6; k++) begin
                if (k % 4 == 0) mk = m_mask(m);
                m = m_next(m);
                exp_d = tbl[k] ^ mk;
                step(1'b1, tbl[k], 1'b1, 1'b0);
                check($sformatf("replay%0d_%0d", r, k), 32'({v_b4, e_b4, d_b4}), 32'({1'b1, 1'b1, exp_d}));
            end
        end
        check("replay_sym", 32'(s_b4), STATS ? 32'd6 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
